// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC select codes and
// the alignment helper used on every non-sequential target.
package pc_pkg;

  localparam logic [1:0] SEL_SEQ = 2'd0;
  localparam logic [1:0] SEL_BR  = 2'd1;
  localparam logic [1:0] SEL_JMP = 2'd2;
  localparam logic [1:0] SEL_RET = 2'd3;

  // Widest PC the helper can handle; callers zero-extend into this width.
  localparam int ADDR_MAX_W = 64;

  function automatic logic [ADDR_MAX_W-1:0] align(input logic [ADDR_MAX_W-1:0] addr,
                                                  input int instr_bytes);
    logic [ADDR_MAX_W-1:0] mask;
    mask = ADDR_MAX_W'(instr_bytes - 1);
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry; overflow and underflow raise a one-cycle err pulse.
module pc_ras
  import pc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] count;

  // wr_ptr names the next free slot, so the newest entry sits just below it.
  assign top_ptr = wr_ptr - PTR_W'(1);
  assign top     = mem[top_ptr];
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      err <= (push && full) || (pop && empty);
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (!full) count <= count + CNT_W'(1);
      end else if (pop && !empty) begin
        wr_ptr <= top_ptr;
        count  <= count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC mux, alignment check and PC register.
// Define PC_RAS_EN to build in the return-address stack (pc_ras).
module pc_unit
  import pc_pkg::*;
#(
  parameter int              PC_W        = 16,
  parameter int              INSTR_BYTES = 2,
  parameter logic [PC_W-1:0] RESET_VEC   = '0,
  parameter logic [PC_W-1:0] TRAP_VEC    = 16'hFF00,
  parameter int              RAS_DEPTH   = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            trap,
  input  logic [1:0]      sel,
  input  logic [PC_W-1:0] offset,
  input  logic [PC_W-1:0] target,
  input  logic            call,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_seq,
  output logic            misalign,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err
);

  logic [PC_W-1:0]       raw;
  logic [PC_W-1:0]       pc_next;
  logic [ADDR_MAX_W-1:0] raw_w;
  logic [ADDR_MAX_W-1:0] aligned_w;
  logic                  do_align;
  logic                  mis_next;
  logic                  advance;

  assign pc_seq  = pc + PC_W'(INSTR_BYTES);
  assign advance = !trap && !stall;

`ifdef PC_RAS_EN
  logic            ras_push;
  logic            ras_pop;
  logic [PC_W-1:0] ras_top;

  pc_ras #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_seq),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .err       (ras_err)
  );

  // Only a real update may touch the stack; RET+call never pushes.
  assign ras_push = advance && call && (sel == SEL_BR || sel == SEL_JMP);
  assign ras_pop  = advance && (sel == SEL_RET);
`else
  logic unused_call;
  assign unused_call = call;
  assign ras_empty   = 1'b1;
  assign ras_full    = 1'b0;
  assign ras_err     = 1'b0;
`endif

  always_comb begin
    raw      = pc_seq;
    do_align = 1'b0;
    unique case (sel)
      SEL_SEQ: raw = pc_seq;
      SEL_BR: begin
        raw      = pc + offset;
        do_align = 1'b1;
      end
      SEL_JMP: begin
        raw      = target;
        do_align = 1'b1;
      end
      default: begin
`ifdef PC_RAS_EN
        raw      = ras_empty ? target : ras_top;
`else
        raw      = target;
`endif
        do_align = 1'b1;
      end
    endcase

    raw_w            = '0;
    raw_w[PC_W-1:0]  = raw;
    aligned_w        = do_align ? align(raw_w, INSTR_BYTES) : raw_w;
    mis_next         = (aligned_w != raw_w);

    if (trap)       pc_next = TRAP_VEC;
    else if (stall) pc_next = pc;
    else            pc_next = aligned_w[PC_W-1:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= RESET_VEC;
      misalign <= 1'b0;
    end else begin
      pc       <= pc_next;
      misalign <= advance && mis_next;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: expected {ras_err, misalign, pc} triples are
// queued as each step is driven and popped after the following clock edge.
module tb_pc_unit;
  import pc_pkg::*;

  localparam int PC_W = 16;
  localparam int W    = PC_W + 2;

  logic            clock;
  logic            reset_n;
  logic            stall;
  logic            trap;
  logic [1:0]      sel;
  logic [PC_W-1:0] offset;
  logic [PC_W-1:0] target;
  logic            call;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_seq;
  logic            misalign;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_err;

  logic [W-1:0] exp_q[$];
  int tests_run;
  int tests_failed;
  int err_seen;

  pc_unit dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .stall     (stall),
    .trap      (trap),
    .sel       (sel),
    .offset    (offset),
    .target    (target),
    .call      (call),
    .pc        (pc),
    .pc_seq    (pc_seq),
    .misalign  (misalign),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_err   (ras_err)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset_n && ras_err) err_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: one clocked step with its expected outcome.
  task automatic step(input string tag, input logic [1:0] s, input logic [PC_W-1:0] off,
                      input logic [PC_W-1:0] tgt, input logic c, input logic st, input logic tr,
                      input logic [PC_W-1:0] e_pc, input logic e_mis, input logic e_err);
    logic [W-1:0] e;
    sel    = s;
    offset = off;
    target = tgt;
    call   = c;
    stall  = st;
    trap   = tr;
    exp_q.push_back({e_err, e_mis, e_pc});
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check({tag, ".pc"}, 32'(pc), 32'(e[PC_W-1:0]));
    check({tag, ".mis"}, 32'(misalign), 32'(e[PC_W]));
    check({tag, ".err"}, 32'(ras_err), 32'(e[PC_W+1]));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    err_seen     = 0;
    reset_n      = 1'b0;
    stall        = 1'b0;
    trap         = 1'b0;
    sel          = SEL_SEQ;
    offset       = '0;
    target       = '0;
    call         = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check("reset.pc", 32'(pc), 32'h0000);
    check("reset.empty", 32'(ras_empty), 32'h1);
    check("reset.full", 32'(ras_full), 32'h0);
    check("reset.mis", 32'(misalign), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Sequential and wrap
    step("seq1", SEL_SEQ, '0, '0, 0, 0, 0, 16'h0002, 0, 0);
    step("seq2", SEL_SEQ, '0, '0, 0, 0, 0, 16'h0004, 0, 0);
    step("seq3", SEL_SEQ, '0, '0, 0, 0, 0, 16'h0006, 0, 0);
    step("seq4", SEL_SEQ, '0, '0, 0, 0, 0, 16'h0008, 0, 0);
    check("pc_seq", 32'(pc_seq), 32'h000A);
    step("jmp_top", SEL_JMP, '0, 16'hFFFE, 0, 0, 0, 16'hFFFE, 0, 0);
    step("seq_wrap", SEL_SEQ, '0, '0, 0, 0, 0, 16'h0000, 0, 0);

    // Branch / jump / alignment
    step("jmp10", SEL_JMP, '0, 16'h0010, 0, 0, 0, 16'h0010, 0, 0);
    step("br_back", SEL_BR, 16'hFFF8, '0, 0, 0, 0, 16'h0008, 0, 0);
    step("jmp_odd", SEL_JMP, '0, 16'h0123, 0, 0, 0, 16'h0122, 1, 0);
    step("mis_pulse", SEL_SEQ, '0, '0, 0, 0, 0, 16'h0124, 0, 0);

    // Stall / trap
    step("stall_jmp", SEL_JMP, '0, 16'h0400, 0, 1, 0, 16'h0124, 0, 0);
    step("jmp_odd2", SEL_JMP, '0, 16'h0123, 0, 0, 0, 16'h0122, 1, 0);
    step("stall_mis", SEL_JMP, '0, 16'h0400, 0, 1, 0, 16'h0122, 0, 0);
    step("trap_stall", SEL_JMP, '0, 16'h0400, 0, 1, 1, 16'hFF00, 0, 0);
    step("br_wrap", SEL_BR, 16'h0101, '0, 0, 0, 0, 16'h0000, 1, 0);

    // Asynchronous reset mid-run
    step("jmp50", SEL_JMP, '0, 16'h0050, 0, 0, 0, 16'h0050, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst.pc", 32'(pc), 32'h0000);
    @(negedge clock);
    reset_n = 1'b1;

`ifdef PC_RAS_EN
    step("jmp40", SEL_JMP, '0, 16'h0040, 0, 0, 0, 16'h0040, 0, 0);
    step("call200", SEL_JMP, '0, 16'h0200, 1, 0, 0, 16'h0200, 0, 0);
    check("call.empty", 32'(ras_empty), 32'h0);
    step("ret42", SEL_RET, '0, 16'h0777, 0, 0, 0, 16'h0042, 0, 0);
    check("ret.empty", 32'(ras_empty), 32'h1);
    step("stall_call", SEL_JMP, '0, 16'h0600, 1, 1, 0, 16'h0042, 0, 0);
    check("stall_call.empty", 32'(ras_empty), 32'h1);
    step("call1", SEL_JMP, '0, 16'h0100, 1, 0, 0, 16'h0100, 0, 0);
    step("call2", SEL_JMP, '0, 16'h0200, 1, 0, 0, 16'h0200, 0, 0);
    step("call3", SEL_JMP, '0, 16'h0300, 1, 0, 0, 16'h0300, 0, 0);
    step("call4", SEL_JMP, '0, 16'h0400, 1, 0, 0, 16'h0400, 0, 0);
    check("depth4.full", 32'(ras_full), 32'h1);
    step("call5", SEL_BR, 16'h0100, '0, 1, 0, 0, 16'h0500, 0, 1);
    check("ovf.full", 32'(ras_full), 32'h1);
    step("err_pulse", SEL_SEQ, '0, '0, 0, 0, 0, 16'h0502, 0, 0);
    step("ret_a", SEL_RET, '0, '0, 0, 0, 0, 16'h0402, 0, 0);
    step("ret_b", SEL_RET, '0, '0, 0, 0, 0, 16'h0302, 0, 0);
    step("ret_c", SEL_RET, '0, '0, 0, 0, 0, 16'h0202, 0, 0);
    step("ret_d", SEL_RET, '0, '0, 0, 0, 0, 16'h0102, 0, 0);
    check("drained.empty", 32'(ras_empty), 32'h1);
    step("ret_empty", SEL_RET, '0, 16'h0300, 0, 0, 0, 16'h0300, 0, 1);
    check("underflow.empty", 32'(ras_empty), 32'h1);
`else
    step("ret_jmp", SEL_RET, '0, 16'h0300, 0, 0, 0, 16'h0300, 0, 0);
    step("ret_call", SEL_RET, '0, 16'h0301, 1, 0, 0, 16'h0300, 1, 0);
    step("jmp_call", SEL_JMP, '0, 16'h0500, 1, 0, 0, 16'h0500, 0, 0);
    check("noras.empty", 32'(ras_empty), 32'h1);
    check("noras.full", 32'(ras_full), 32'h0);
    check("noras.err_seen", 32'(err_seen), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
